// File: rtl/boss_life_if.sv
// Boss lifecycle bus: control pulses from the game logic in, sprite/status fields out.
interface boss_life_if;
  logic       move_tick;
  logic       start;
  logic       hit;
  logic       revive;
  logic [9:0] boss_x;
  logic [9:0] boss_y;
  logic       boom;
  logic [3:0] boss_hp;
  logic [2:0] state;
  logic       hit_flash;
  logic       kill_pulse;

  modport master (
    output move_tick, start, hit, revive,
    input  boss_x, boss_y, boom, boss_hp, state, hit_flash, kill_pulse
  );

  modport slave (
    input  move_tick, start, hit, revive,
    output boss_x, boss_y, boom, boss_hp, state, hit_flash, kill_pulse
  );
endinterface

// File: rtl/boss_life_ctrl.sv
// Boss lifecycle FSM: enter, patrol, take hits, flash, explode, die, respawn.
// Define BOSS_AUTO_RESPAWN_EN to leave DEAD automatically after RESPAWN_TICKS move ticks.
module boss_life_ctrl #(
  parameter int HP_MAX        = 8,
  parameter int FLASH_TICKS   = 4,
  parameter int BOOM_TICKS    = 32,
  parameter int RESPAWN_TICKS = 64,
  parameter int STEP          = 2,
  parameter int X_MIN         = 0,
  parameter int X_MAX         = 512,
  parameter int X_HOME        = 256,
  parameter int ENTER_Y       = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  boss_life_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTER   = 3'd1,
    S_FIGHT   = 3'd2,
    S_FLASH   = 3'd3,
    S_EXPLODE = 3'd4,
    S_DEAD    = 3'd5
  } state_t;

  // One counter serves flash, boom and respawn timing; those states never overlap.
  localparam int T_FB  = (FLASH_TICKS > BOOM_TICKS) ? FLASH_TICKS : BOOM_TICKS;
  localparam int T_MAX = (T_FB > RESPAWN_TICKS) ? T_FB : RESPAWN_TICKS;
  localparam int CW    = $clog2(T_MAX + 1) + 1;

  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [10:0] XMIN_W  = 11'(X_MIN);
  localparam logic [10:0] XMAX_W  = 11'(X_MAX);
  localparam logic [10:0] ENTY_W  = 11'(ENTER_Y);
  localparam logic [9:0]  X_HOME_V = 10'(X_HOME);
  localparam logic [3:0]  HP_V     = 4'(HP_MAX);

  state_t        r_state;
  logic [9:0]    r_x, r_y;
  logic [3:0]    r_hp;
  logic          r_dir;      // 0 = moving right, 1 = moving left
  logic          r_boom, r_flash, r_kill, r_hit_q;
  logic [CW-1:0] r_cnt;

  logic          w_tick, w_hit_edge, w_respawn, w_cnt_last;
  logic [10:0]   w_x_ext, w_y_sum;
  logic [9:0]    w_x_nxt;
  logic          w_dir_nxt;

  assign w_tick     = bus.move_tick;
  assign w_hit_edge = bus.hit & ~r_hit_q;
  assign w_cnt_last = (r_cnt <= CW'(1));
  assign w_x_ext    = {1'b0, r_x};
  assign w_y_sum    = {1'b0, r_y} + STEP_W;

  // Reaching a bound counts as hitting it: clamp and reverse in the same tick.
  always_comb begin
    w_x_nxt   = r_x;
    w_dir_nxt = r_dir;
    if (!r_dir) begin
      if (w_x_ext + STEP_W >= XMAX_W) begin
        w_x_nxt   = 10'(X_MAX);
        w_dir_nxt = 1'b1;
      end else begin
        w_x_nxt = r_x + 10'(STEP);
      end
    end else begin
      if (w_x_ext <= XMIN_W + STEP_W) begin
        w_x_nxt   = 10'(X_MIN);
        w_dir_nxt = 1'b0;
      end else begin
        w_x_nxt = r_x - 10'(STEP);
      end
    end
  end

  always_comb begin
    w_respawn = 1'b0;
    if (r_state == S_DEAD) begin
`ifdef BOSS_AUTO_RESPAWN_EN
      w_respawn = bus.revive | (w_tick & w_cnt_last);
`else
      w_respawn = bus.revive;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_x     <= X_HOME_V;
      r_y     <= '0;
      r_hp    <= HP_V;
      r_dir   <= 1'b0;
      r_boom  <= 1'b0;
      r_flash <= 1'b0;
      r_kill  <= 1'b0;
      r_hit_q <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_hit_q <= bus.hit;
      r_kill  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_x     <= X_HOME_V;
          r_y     <= '0;
          r_hp    <= HP_V;
          r_dir   <= 1'b0;
          r_boom  <= 1'b0;
          r_flash <= 1'b0;
          r_cnt   <= '0;
          if (bus.start) r_state <= S_ENTER;
        end
        S_ENTER: begin
          if (w_tick) begin
            if (w_y_sum >= ENTY_W) begin
              r_y     <= 10'(ENTER_Y);
              r_state <= S_FIGHT;
            end else begin
              r_y <= w_y_sum[9:0];
            end
          end
        end
        S_FIGHT: begin
          if (w_tick) begin
            r_x   <= w_x_nxt;
            r_dir <= w_dir_nxt;
          end
          if (w_hit_edge) begin
            r_hp <= r_hp - 4'd1;
            if (r_hp == 4'd1) begin
              r_state <= S_EXPLODE;
              r_kill  <= 1'b1;
              r_boom  <= 1'b1;
              r_cnt   <= CW'(BOOM_TICKS);
            end else begin
              r_state <= S_FLASH;
              r_flash <= 1'b1;
              r_cnt   <= CW'(FLASH_TICKS);
            end
          end
        end
        S_FLASH: begin
          if (w_tick) begin
            r_x   <= w_x_nxt;
            r_dir <= w_dir_nxt;
            if (w_cnt_last) begin
              r_state <= S_FIGHT;
              r_flash <= 1'b0;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
        end
        S_EXPLODE: begin
          if (w_tick) begin
            if (w_cnt_last) begin
              r_state <= S_DEAD;
              r_boom  <= 1'b0;
`ifdef BOSS_AUTO_RESPAWN_EN
              r_cnt   <= CW'(RESPAWN_TICKS);
`else
              r_cnt   <= '0;
`endif
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
        end
        S_DEAD: begin
          if (w_respawn) begin
            r_state <= S_ENTER;
            r_hp    <= HP_V;
            r_x     <= X_HOME_V;
            r_y     <= '0;
            r_dir   <= 1'b0;
            r_cnt   <= '0;
          end
`ifdef BOSS_AUTO_RESPAWN_EN
          else if (w_tick) begin
            r_cnt <= r_cnt - CW'(1);
          end
`endif
        end
        default: begin
          r_state <= S_IDLE;
          r_x     <= X_HOME_V;
          r_y     <= '0;
          r_hp    <= HP_V;
          r_dir   <= 1'b0;
          r_boom  <= 1'b0;
          r_flash <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.boss_x     = r_x;
  assign bus.boss_y     = r_y;
  assign bus.boom       = r_boom;
  assign bus.boss_hp    = r_hp;
  assign bus.state      = r_state;
  assign bus.hit_flash  = r_flash;
  assign bus.kill_pulse = r_kill;

endmodule

// File: tb/tb_boss_life_ctrl.sv
// Directed bench for boss_life_ctrl: entry, patrol bounds, hits, explode, death/respawn, reset.
module tb_boss_life_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hit_lvl = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ex;
  bit   mv = 1'b0;

  boss_life_if bus ();

  boss_life_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drive one clock's worth of inputs at negedge, return 1ns after the rising edge.
  task automatic cyc(input logic mt, input logic st, input logic rv);
    @(negedge clk);
    bus.move_tick = mt;
    bus.start     = st;
    bus.revive    = rv;
    bus.hit       = hit_lvl;
    @(posedge clk);
    #1;
  endtask

  task automatic tk();
    cyc(1'b1, 1'b0, 1'b0);
    if (mv) ex = ex - 2;
  endtask

  initial begin
    bus.move_tick = 1'b0;
    bus.start     = 1'b0;
    bus.hit       = 1'b0;
    bus.revive    = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_x", 32'(bus.boss_x), 256);
    chk("rst_y", 32'(bus.boss_y), 0);
    chk("rst_hp", 32'(bus.boss_hp), 8);
    chk("rst_boom", 32'(bus.boom), 0);
    chk("rst_flash", 32'(bus.hit_flash), 0);
    chk("rst_kill", 32'(bus.kill_pulse), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ticks in IDLE do nothing; start enters one clk later
    cyc(1'b1, 1'b0, 1'b0);
    chk("idle_tick_state", 32'(bus.state), 0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("start_enter", 32'(bus.state), 1);
    chk("enter_y0", 32'(bus.boss_y), 0);

    // ENTER: y climbs by 2 per tick, move_tick every 4 clk
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk("enter_y", 32'(bus.boss_y), 32'(2 * k));
      chk("enter_state", 32'(bus.state), (k == 20) ? 32'd2 : 32'd1);
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
    end
    chk("fight_x", 32'(bus.boss_x), 256);

    // Patrol to the right bound and bounce
    repeat (127) cyc(1'b1, 1'b0, 1'b0);
    chk("x_510", 32'(bus.boss_x), 510);
    cyc(1'b1, 1'b0, 1'b0);
    chk("x_clamp_512", 32'(bus.boss_x), 512);
    cyc(1'b1, 1'b0, 1'b0);
    chk("x_back_510", 32'(bus.boss_x), 510);
    ex = 510;
    mv = 1'b1;

    // Hit 1 held high through FLASH and back into FIGHT
    hit_lvl = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("hit1_hp", 32'(bus.boss_hp), 7);
    chk("hit1_state", 32'(bus.state), 3);
    chk("hit1_flash", 32'(bus.hit_flash), 1);
    repeat (3) tk();
    chk("flash_hold", 32'(bus.state), 3);
    tk();
    chk("flash_done", 32'(bus.state), 2);
    chk("flash_off", 32'(bus.hit_flash), 0);
    repeat (2) tk();
    chk("held_hp", 32'(bus.boss_hp), 7);
    chk("held_state", 32'(bus.state), 2);
    chk("patrol_x", 32'(bus.boss_x), 32'(ex));
    hit_lvl = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);

    // Hit 2, then a fresh edge during FLASH is ignored
    hit_lvl = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("hit2_hp", 32'(bus.boss_hp), 6);
    hit_lvl = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    hit_lvl = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("flash_edge_hp", 32'(bus.boss_hp), 6);
    hit_lvl = 1'b0;
    repeat (4) tk();
    chk("hit2_back", 32'(bus.state), 2);

    // Hits 3..7, each followed by FLASH_TICKS+1 ticks
    for (int i = 3; i <= 7; i++) begin
      hit_lvl = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      chk("hitn_hp", 32'(bus.boss_hp), 32'(8 - i));
      chk("hitn_state", 32'(bus.state), 3);
      chk("hitn_kill", 32'(bus.kill_pulse), 0);
      hit_lvl = 1'b0;
      repeat (5) tk();
      chk("hitn_fight", 32'(bus.state), 2);
    end

    // Fatal hit coincides with a move tick: both take effect
    hit_lvl = 1'b1;
    tk();
    mv = 1'b0;
    chk("kill_hp", 32'(bus.boss_hp), 0);
    chk("kill_state", 32'(bus.state), 4);
    chk("kill_pulse", 32'(bus.kill_pulse), 1);
    chk("kill_boom", 32'(bus.boom), 1);
    chk("kill_x", 32'(bus.boss_x), 32'(ex));
    hit_lvl = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk("kill_pulse_off", 32'(bus.kill_pulse), 0);
    chk("boom_hold", 32'(bus.boom), 1);

    // EXPLODE freezes motion and lasts 32 ticks
    tk();
    chk("boom_freeze_x", 32'(bus.boss_x), 32'(ex));
    repeat (30) tk();
    chk("boom_31", 32'(bus.state), 4);
    chk("boom_31_flag", 32'(bus.boom), 1);
    tk();
    chk("dead_state", 32'(bus.state), 5);
    chk("dead_boom", 32'(bus.boom), 0);

`ifdef BOSS_AUTO_RESPAWN_EN
    repeat (63) tk();
    chk("dead_63", 32'(bus.state), 5);
    tk();
`else
    repeat (70) tk();
    chk("dead_wait", 32'(bus.state), 5);
    cyc(1'b0, 1'b0, 1'b1);
`endif
    chk("respawn_state", 32'(bus.state), 1);
    chk("respawn_hp", 32'(bus.boss_hp), 8);
    chk("respawn_x", 32'(bus.boss_x), 256);
    chk("respawn_y", 32'(bus.boss_y), 0);

    // start/revive outside their states are ignored
    cyc(1'b0, 1'b1, 1'b0);
    chk("start_ignored", 32'(bus.state), 1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("revive_ignored", 32'(bus.state), 1);

    // Back to FIGHT, take a hit, then reset asynchronously mid-FLASH
    repeat (20) cyc(1'b1, 1'b0, 1'b0);
    chk("refight", 32'(bus.state), 2);
    hit_lvl = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("reflash", 32'(bus.state), 3);
    hit_lvl = 1'b0;
    bus.hit = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_state", 32'(bus.state), 0);
    chk("async_hp", 32'(bus.boss_hp), 8);
    chk("async_flash", 32'(bus.hit_flash), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) cyc(1'b1, 1'b0, 1'b0);
    chk("post_rst_idle", 32'(bus.state), 0);
    chk("post_rst_y", 32'(bus.boss_y), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
